// File: rtl/dcache_ctrl_pkg.sv
// Shared geometry, address helpers and FSM state encoding for the L1 data cache controller.
// Imported by the RTL and by the testbench.
package dcache_ctrl_pkg;

  localparam int NUM_SETS  = 16;
  localparam int IDX_W     = 4;
  localparam int OFF_W     = 5;
  localparam int ADDR_W    = 32;
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_BITS = 256;
  localparam int WORD_W    = 32;
  localparam int WORDS     = LINE_BITS / WORD_W;
  localparam int WSEL_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_MISS        = 3'd1,
    ST_WRITEBACK   = 3'd2,
    ST_REFILL      = 3'd3,
    ST_REFILL_DONE = 3'd4
  } state_e;

  function automatic logic [TAG_W-1:0] addrTag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addrIdx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [WSEL_W-1:0] addrWord(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:2];
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side bus of the data cache controller.
// master = cache controller, slave = pipeline/memory environment.
interface dcache_ctrl_if;
  import dcache_ctrl_pkg::*;

  logic [ADDR_W-1:0]    cpu_addr_i;
  logic [WORD_W-1:0]    cpu_data_i;
  logic                 cpu_MemRead_i;
  logic                 cpu_MemWrite_i;
  logic [WORD_W-1:0]    cpu_data_o;
  logic                 cpu_stall_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic [LINE_BITS-1:0] mem_data_o;
  logic                 mem_enable_o;
  logic                 mem_write_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;

  modport master (
    input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
  );

  modport slave (
    output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
  );

endinterface

// File: rtl/dcache_ctrl_sram.sv
// Tag, valid, dirty and data arrays of the direct-mapped cache (module dcache_sram).
// Combinational read, posedge write with per-word enable, synchronous reset of valid/dirty.
module dcache_sram
  import dcache_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_W-1:0]     idx_i,
  output logic [TAG_W-1:0]     tag_o,
  output logic                 valid_o,
  output logic                 dirty_o,
  output logic [LINE_BITS-1:0] line_o,
  input  logic                 lineWe_i,
  input  logic [TAG_W-1:0]     lineTag_i,
  input  logic [LINE_BITS-1:0] lineData_i,
  input  logic [WORDS-1:0]     wordWe_i,
  input  logic [WORD_W-1:0]    wordData_i,
  input  logic                 setDirty_i,
  input  logic                 clrDirty_i
);

  logic [TAG_W-1:0]     tagArr_q  [NUM_SETS];
  logic [LINE_BITS-1:0] dataArr_q [NUM_SETS];
  logic [NUM_SETS-1:0]  valid_q;
  logic [NUM_SETS-1:0]  dirty_q;

  assign tag_o   = tagArr_q[idx_i];
  assign line_o  = dataArr_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];

  always_ff @(posedge clk_i) begin
    if (lineWe_i) begin
      tagArr_q[idx_i]  <= lineTag_i;
      dataArr_q[idx_i] <= lineData_i;
    end else begin
      for (int w = 0; w < WORDS; w++) begin
        if (wordWe_i[w]) dataArr_q[idx_i][w*WORD_W +: WORD_W] <= wordData_i;
      end
    end
  end

  // A refill always leaves the line clean, even if a store is pending on it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (lineWe_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (setDirty_i) begin
      dirty_q[idx_i] <= 1'b1;
    end else if (clrDirty_i) begin
      dirty_q[idx_i] <= 1'b0;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 data cache controller with miss FSM.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  dcache_ctrl_if.master      bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o
`endif
);

  state_e               state_q;
  logic                 memEnable_q;
  logic                 memWrite_q;
  logic [ADDR_W-1:0]    memAddr_q;

  logic [ADDR_W-1:0]    addr;
  logic [TAG_W-1:0]     reqTag;
  logic [IDX_W-1:0]     idx;
  logic [WSEL_W-1:0]    wsel;
  logic                 req;
  logic                 isStore;
  logic                 isLoad;
  logic [TAG_W-1:0]     lineTag;
  logic                 lineValid;
  logic                 lineDirty;
  logic [LINE_BITS-1:0] line;
  logic                 hit;
  logic                 serve;
  logic                 refillWe;
  logic                 wbDone;
  logic [WORDS-1:0]     wordWe;
  logic [1:0]           unusedAddrBits;

  assign addr           = bus.cpu_addr_i;
  assign reqTag         = addrTag(addr);
  assign idx            = addrIdx(addr);
  assign wsel           = addrWord(addr);
  assign unusedAddrBits = addr[1:0];

  // A simultaneous read and write request is treated as a store.
  assign req     = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
  assign isStore = bus.cpu_MemWrite_i;
  assign isLoad  = bus.cpu_MemRead_i & ~bus.cpu_MemWrite_i;

  assign hit      = lineValid & (lineTag == reqTag);
  assign serve    = (state_q == ST_IDLE) & req & hit;
  assign refillWe = (state_q == ST_REFILL) & bus.mem_ack_i;
  assign wbDone   = (state_q == ST_WRITEBACK) & bus.mem_ack_i;

  always_comb begin
    wordWe = '0;
    if (serve & isStore) wordWe[wsel] = 1'b1;
  end

  dcache_sram u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idx_i      (idx),
    .tag_o      (lineTag),
    .valid_o    (lineValid),
    .dirty_o    (lineDirty),
    .line_o     (line),
    .lineWe_i   (refillWe),
    .lineTag_i  (reqTag),
    .lineData_i (bus.mem_data_i),
    .wordWe_i   (wordWe),
    .wordData_i (bus.cpu_data_i),
    .setDirty_i (serve & isStore),
    .clrDirty_i (wbDone)
  );

  assign bus.cpu_stall_o  = req & ~((state_q == ST_IDLE) & hit);
  assign bus.cpu_data_o   = (serve & isLoad) ? line[wsel*WORD_W +: WORD_W] : '0;
  assign bus.mem_addr_o   = memAddr_q;
  assign bus.mem_data_o   = line;
  assign bus.mem_enable_o = memEnable_q;
  assign bus.mem_write_o  = memWrite_q;

  // MISS always separates write-back and refill, so enable drops for a cycle between them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      memEnable_q <= 1'b0;
      memWrite_q  <= 1'b0;
      memAddr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req & ~hit) state_q <= ST_MISS;
        end
        ST_MISS: begin
          memEnable_q <= 1'b1;
          if (lineDirty) begin
            state_q    <= ST_WRITEBACK;
            memWrite_q <= 1'b1;
            memAddr_q  <= {lineTag, idx, {OFF_W{1'b0}}};
          end else begin
            state_q    <= ST_REFILL;
            memWrite_q <= 1'b0;
            memAddr_q  <= {reqTag, idx, {OFF_W{1'b0}}};
          end
        end
        ST_WRITEBACK: begin
          if (bus.mem_ack_i) begin
            state_q     <= ST_MISS;
            memEnable_q <= 1'b0;
            memWrite_q  <= 1'b0;
          end
        end
        ST_REFILL: begin
          if (bus.mem_ack_i) begin
            state_q     <= ST_REFILL_DONE;
            memEnable_q <= 1'b0;
          end
        end
        ST_REFILL_DONE: state_q <= ST_IDLE;
        default:        state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic        prevDone_q;
  logic [31:0] hitCnt_q;
  logic [31:0] missCnt_q;

  // The hit that completes a miss is not counted as a hit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prevDone_q <= 1'b0;
      hitCnt_q   <= '0;
      missCnt_q  <= '0;
    end else begin
      prevDone_q <= (state_q == ST_REFILL_DONE);
      if ((state_q == ST_IDLE) & req & ~hit & (missCnt_q != 32'hFFFF_FFFF))
        missCnt_q <= missCnt_q + 32'd1;
      if (serve & ~prevDone_q & (hitCnt_q != 32'hFFFF_FFFF))
        hitCnt_q <= hitCnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hitCnt_q;
  assign miss_cnt_o = missCnt_q;
`endif

endmodule
